// File: rtl/hasti_arb_ctrl.sv
// hasti_arb_ctrl: round-robin address-phase arbiter and stall control for the shared HASTI slave port.
// Build option: define HASTI_ARB_LOCK_EN to let the last issued master keep the bus while hmastlock is held.
module hasti_arb_ctrl #(
    parameter int NUM_M = 2
) (
    input  logic               hclk,
    input  logic               hreset,
    input  logic [NUM_M-1:0]   m_hsel,
    input  logic [2*NUM_M-1:0] m_htrans,
    input  logic [NUM_M-1:0]   m_hmastlock,
    input  logic               s_hreadyout,
    output logic [NUM_M-1:0]   m_hreadyout,
    output logic [NUM_M-1:0]   capture,
    output logic [NUM_M-1:0]   addr_sel,
    output logic               addr_from_buf,
    output logic               s_trans_vld,
    output logic [NUM_M-1:0]   dphase_sel
);
    localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

    logic [NUM_M-1:0] pending;
    logic [NUM_M-1:0] trans_act;
    logic [NUM_M-1:0] access;
    logic [NUM_M-1:0] req;
    logic [NUM_M-1:0] win_oh;
    logic [NUM_M-1:0] sel_q;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    rr_win;
    logic [IW-1:0]    winner;
    logic             from_buf_q;
    logic             vld_q;
    logic             any_req;
    logic             found;

    always_comb begin
        trans_act = '0;
        for (int i = 0; i < NUM_M; i++) begin
            trans_act[i] = m_htrans[2*i+1];
        end
    end

    // A pending master is held off until its buffered transfer's data phase completes.
    assign m_hreadyout = (dphase_sel & {NUM_M{s_hreadyout}}) | (~dphase_sel & ~pending);
    assign access      = m_hsel & trans_act & m_hreadyout;
    assign req         = pending | access;
    assign any_req     = |req;

    always_comb begin
        rr_win = rr_ptr;
        found  = 1'b0;
        for (int k = 0; k < NUM_M; k++) begin
            if (!found && req[(int'(rr_ptr) + k) % NUM_M]) begin
                rr_win = IW'((int'(rr_ptr) + k) % NUM_M);
                found  = 1'b1;
            end
        end
    end

`ifdef HASTI_ARB_LOCK_EN
    logic          lock_vld;
    logic [IW-1:0] lock_idx;
    logic          locked;

    assign locked = lock_vld & m_hmastlock[lock_idx] & req[lock_idx];
    assign winner = locked ? lock_idx : rr_win;

    // Lock owner is the master issued on the last accepted address phase; an idle issue clears it.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            lock_vld <= 1'b0;
            lock_idx <= '0;
        end else if (s_hreadyout) begin
            lock_vld <= any_req;
            lock_idx <= winner;
        end
    end
`else
    logic unused_hmastlock;

    assign unused_hmastlock = ^m_hmastlock;
    assign winner           = rr_win;
`endif

    assign win_oh = NUM_M'(1) << winner;

    always_comb begin
        capture       = '0;
        addr_sel      = sel_q;
        addr_from_buf = from_buf_q;
        s_trans_vld   = vld_q;
        if (hreset) begin
            addr_sel      = NUM_M'(1);
            addr_from_buf = 1'b0;
            s_trans_vld   = 1'b0;
        end else if (s_hreadyout) begin
            capture       = access & ~win_oh;
            s_trans_vld   = any_req;
            addr_from_buf = any_req & pending[winner];
            if (any_req) begin
                addr_sel = win_oh;
            end
        end else begin
            // Slave stalled: nothing is issued, so every new access must be buffered.
            capture = access;
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            pending    <= '0;
            rr_ptr     <= '0;
            dphase_sel <= '0;
            sel_q      <= NUM_M'(1);
            from_buf_q <= 1'b0;
            vld_q      <= 1'b0;
        end else if (s_hreadyout) begin
            sel_q      <= addr_sel;
            from_buf_q <= addr_from_buf;
            vld_q      <= s_trans_vld;
            if (any_req) begin
                pending    <= (pending | capture) & ~win_oh;
                dphase_sel <= win_oh;
                rr_ptr     <= (int'(winner) == NUM_M - 1) ? '0 : winner + IW'(1);
            end else begin
                pending    <= pending | capture;
                dphase_sel <= '0;
            end
        end else begin
            pending <= pending | capture;
        end
    end
endmodule

// File: tb/tb_hasti_arb_ctrl.sv
// tb_hasti_arb_ctrl: directed vector table, corner sequences and random traffic against a rule-level model.
// Expected lock behaviour follows HASTI_ARB_LOCK_EN as defined for the build.
module tb_hasti_arb_ctrl;
    localparam int NM = 2;

    logic            hclk = 1'b0;
    logic            hreset;
    logic [NM-1:0]   m_hsel;
    logic [2*NM-1:0] m_htrans;
    logic [NM-1:0]   m_hmastlock;
    logic            s_hreadyout;
    logic [NM-1:0]   m_hreadyout;
    logic [NM-1:0]   capture;
    logic [NM-1:0]   addr_sel;
    logic            addr_from_buf;
    logic            s_trans_vld;
    logic [NM-1:0]   dphase_sel;

    int total = 0;
    int bad   = 0;

    always #5 hclk = ~hclk;

    hasti_arb_ctrl #(.NUM_M(NM)) dut (
        .hclk(hclk), .hreset(hreset), .m_hsel(m_hsel), .m_htrans(m_htrans),
        .m_hmastlock(m_hmastlock), .s_hreadyout(s_hreadyout), .m_hreadyout(m_hreadyout),
        .capture(capture), .addr_sel(addr_sel), .addr_from_buf(addr_from_buf),
        .s_trans_vld(s_trans_vld), .dphase_sel(dphase_sel)
    );

    // Reference model state: integers, -1 meaning "none".
    bit mp[NM];
    int m_rr, m_dph, m_lock, m_asel, m_win;
    bit m_fbuf, m_vld, m_any;
    logic [NM-1:0] e_hr, e_cap, e_asel, e_dph;
    logic e_fbuf, e_vld;

    // DUT snapshot taken at the check point of each cycle.
    logic [NM-1:0] o_hr, o_cap, o_asel, o_dph;
    logic o_fbuf, o_vld;
    int grants[$];

    typedef struct {
        logic [1:0] hsel;
        logic [3:0] htrans;
        logic       sr;
        logic [1:0] asel;
        logic       fbuf;
        logic       vld;
        logic [1:0] cap;
        logic [1:0] hr;
        logic [1:0] dph;
    } vec_t;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NM; i++) mp[i] = 1'b0;
        m_rr = 0; m_dph = -1; m_lock = -1; m_asel = 0; m_fbuf = 0; m_vld = 0;
    endtask

    task automatic model_outputs(input logic [NM-1:0] hs, input logic [2*NM-1:0] ht,
                                 input logic [NM-1:0] lk, input logic sr);
        bit acc[NM];
        bit rq[NM];
        m_any = 0;
        m_win = -1;
        for (int i = 0; i < NM; i++) begin
            e_hr[i] = (m_dph == i) ? sr : !mp[i];
            acc[i]  = hs[i] && ht[2*i+1] && e_hr[i];
            rq[i]   = mp[i] || acc[i];
            if (rq[i]) m_any = 1;
        end
        if (sr && m_any) begin
`ifdef HASTI_ARB_LOCK_EN
            if (m_lock >= 0 && lk[m_lock] && rq[m_lock]) m_win = m_lock;
`else
            if (lk == '1 && m_lock < -1) m_win = 0;
`endif
            for (int k = 0; k < NM; k++)
                if (m_win < 0 && rq[(m_rr + k) % NM]) m_win = (m_rr + k) % NM;
        end
        e_cap = '0; e_asel = '0; e_dph = '0;
        if (m_dph >= 0) e_dph[m_dph] = 1'b1;
        if (sr) begin
            e_vld  = m_any;
            e_fbuf = m_any && mp[m_win];
            if (m_any) e_asel[m_win] = 1'b1; else e_asel[m_asel] = 1'b1;
            for (int i = 0; i < NM; i++) e_cap[i] = acc[i] && (i != m_win);
        end else begin
            e_vld  = m_vld;
            e_fbuf = m_fbuf;
            e_asel[m_asel] = 1'b1;
            for (int i = 0; i < NM; i++) e_cap[i] = acc[i];
        end
    endtask

    task automatic model_commit(input logic sr);
        for (int i = 0; i < NM; i++) if (e_cap[i]) mp[i] = 1'b1;
        if (sr) begin
            if (m_any) begin
                mp[m_win] = 1'b0;
                m_dph  = m_win;
                m_rr   = (m_win + 1) % NM;
                m_lock = m_win;
                m_asel = m_win;
            end else begin
                m_dph  = -1;
                m_lock = -1;
            end
            m_fbuf = e_fbuf;
            m_vld  = e_vld;
        end
    endtask

    // One bus cycle: drive after the falling edge, check before the rising edge.
    task automatic cyc(input logic [NM-1:0] hs, input logic [2*NM-1:0] ht,
                       input logic [NM-1:0] lk, input logic sr);
        m_hsel = hs; m_htrans = ht; m_hmastlock = lk; s_hreadyout = sr;
        #2;
        o_hr = m_hreadyout; o_cap = capture; o_asel = addr_sel; o_dph = dphase_sel;
        o_fbuf = addr_from_buf; o_vld = s_trans_vld;
        model_outputs(hs, ht, lk, sr);
        chk("m_hreadyout", o_hr, e_hr);
        chk("capture", o_cap, e_cap);
        chk("addr_sel", o_asel, e_asel);
        chk("addr_from_buf", o_fbuf, e_fbuf);
        chk("s_trans_vld", o_vld, e_vld);
        chk("dphase_sel", o_dph, e_dph);
        if (o_vld && sr)
            for (int i = 0; i < NM; i++) if (o_asel[i]) grants.push_back(i);
        model_commit(sr);
        @(negedge hclk);
    endtask

    task automatic do_reset();
        hreset = 1'b1;
        m_hsel = '0; m_htrans = '0; m_hmastlock = '0; s_hreadyout = 1'b1;
        @(negedge hclk);
        hreset = 1'b0;
        model_reset();
    endtask

    vec_t tbl[11];
    int   exp_g[5];
    int   n0, n1, rep, b;
    logic [1:0] ht1;

    initial begin
        tbl[0]  = '{2'b00, 4'b0000, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 2'b11, 2'b00};
        tbl[1]  = '{2'b11, 4'b1010, 1'b1, 2'b01, 1'b0, 1'b1, 2'b10, 2'b11, 2'b00};
        tbl[2]  = '{2'b11, 4'b1010, 1'b1, 2'b10, 1'b1, 1'b1, 2'b01, 2'b01, 2'b01};
        tbl[3]  = '{2'b00, 4'b0000, 1'b0, 2'b10, 1'b1, 1'b1, 2'b00, 2'b00, 2'b10};
        tbl[4]  = '{2'b00, 4'b0000, 1'b0, 2'b10, 1'b1, 1'b1, 2'b00, 2'b00, 2'b10};
        tbl[5]  = '{2'b00, 4'b0000, 1'b0, 2'b10, 1'b1, 1'b1, 2'b00, 2'b00, 2'b10};
        tbl[6]  = '{2'b00, 4'b0000, 1'b1, 2'b01, 1'b1, 1'b1, 2'b00, 2'b10, 2'b10};
        tbl[7]  = '{2'b00, 4'b0000, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 2'b11, 2'b01};
        tbl[8]  = '{2'b10, 4'b1000, 1'b1, 2'b10, 1'b0, 1'b1, 2'b00, 2'b11, 2'b00};
        tbl[9]  = '{2'b10, 4'b0100, 1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 2'b11, 2'b10};
        tbl[10] = '{2'b00, 4'b0011, 1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 2'b11, 2'b00};

        hreset = 1'b1;
        m_hsel = '0; m_htrans = '0; m_hmastlock = '0; s_hreadyout = 1'b1;
        model_reset();
        #1;
        chk("rst_hreadyout", m_hreadyout, 2'b11);
        chk("rst_dphase", dphase_sel, 2'b00);
        chk("rst_vld", s_trans_vld, 1'b0);
        chk("rst_addr_sel", addr_sel, 2'b01);
        @(negedge hclk);
        hreset = 1'b0;

        // Directed table: idle, collision, slave wait on buffered issue, lone m1, BUSY, unselected SEQ.
        for (int v = 0; v < 11; v++) begin
            cyc(tbl[v].hsel, tbl[v].htrans, 2'b00, tbl[v].sr);
            chk($sformatf("tbl%0d_addr_sel", v), o_asel, tbl[v].asel);
            chk($sformatf("tbl%0d_from_buf", v), o_fbuf, tbl[v].fbuf);
            chk($sformatf("tbl%0d_vld", v), o_vld, tbl[v].vld);
            chk($sformatf("tbl%0d_capture", v), o_cap, tbl[v].cap);
            chk($sformatf("tbl%0d_hready", v), o_hr, tbl[v].hr);
            chk($sformatf("tbl%0d_dphase", v), o_dph, tbl[v].dph);
        end

        // Reset mid-cycle with a buffered transfer and live requests present.
        cyc(2'b11, 4'b1010, 2'b00, 1'b1);
        m_hsel = 2'b11; m_htrans = 4'b1010; s_hreadyout = 1'b1;
        #2 hreset = 1'b1;
        #1;
        chk("midrst_hreadyout", m_hreadyout, 2'b11);
        chk("midrst_dphase", dphase_sel, 2'b00);
        chk("midrst_vld", s_trans_vld, 1'b0);
        chk("midrst_addr_sel", addr_sel, 2'b01);
        chk("midrst_capture", capture, 2'b00);
        chk("midrst_from_buf", addr_from_buf, 1'b0);
        @(negedge hclk);
        hreset = 1'b0;
        model_reset();
        cyc(2'b00, 4'b0000, 2'b00, 1'b1);

        // Fairness: both masters request back to back.
        do_reset();
        grants.delete();
        for (int c = 0; c < 40 && grants.size() < 20; c++) cyc(2'b11, 4'b1010, 2'b00, 1'b1);
        chk("fair_grant_count", (grants.size() >= 20) ? 8'd1 : 8'd0, 8'd1);
        n0 = 0; n1 = 0; rep = 0;
        for (int g = 0; g < 20 && g < grants.size(); g++) begin
            if (grants[g] == 0) n0++; else n1++;
            if (g > 0 && grants[g] == grants[g-1]) rep++;
        end
        chk("fair_m0_in_range", (n0 >= 9 && n0 <= 11) ? 8'd1 : 8'd0, 8'd1);
        chk("fair_m1_in_range", (n1 >= 9 && n1 <= 11) ? 8'd1 : 8'd0, 8'd1);
        chk("fair_alternate", 8'(rep), 8'd0);

        // Lock: m1 runs a 4-beat locked burst starting alone; m0 joins on the next cycle.
        do_reset();
        grants.delete();
        b = 0;
        for (int c = 0; c < 12; c++) begin
            ht1 = (b == 0) ? 2'b10 : 2'b11;
            if (b < 4) cyc({1'b1, (c > 0)}, {ht1, (c > 0) ? 2'b10 : 2'b00}, 2'b10, 1'b1);
            else       cyc({1'b0, 1'b1}, 4'b0010, 2'b00, 1'b1);
            if (b < 4 && e_hr[1]) b++;
        end
`ifdef HASTI_ARB_LOCK_EN
        exp_g = '{1, 1, 1, 1, 0};
`else
        exp_g = '{1, 0, 1, 0, 1};
`endif
        chk("lock_grant_count", (grants.size() >= 5) ? 8'd1 : 8'd0, 8'd1);
        for (int g = 0; g < 5 && g < grants.size(); g++)
            chk($sformatf("lock_grant%0d", g), 8'(grants[g]), 8'(exp_g[g]));

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 400; c++)
            cyc(2'($urandom), 4'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
